regs_xys: RTL
=============

# regs_xys

Index/stack register file that consumes the register-control strobes (Y_SB, X_SB, S_SB, SB_X, SB_Y, SB_S, S_S, S_ADL) and implements the 8-bit X, Y and S registers on the special bus (SB) and the low address bus (ADL). It runs from one clock, and an internal phase bit derives the PHI1/PHI2 half-cycles. It exports those half-cycles so the upstream control stage can use them. S is modelled as a two-stage input/output latch pair, so S reads and writes can share one PHI1 half.

## Interface
- No parameters; data width is fixed at 8.
- PHI0  in  1  clock; every rising edge ends one half-cycle.
- n_RES  in  1  asynchronous, active-low reset.
- Y_SB, X_SB, S_SB  in  1 each  drive Y / X / S onto SB (sampled only in the PHI1 half).
- SB_X, SB_Y, SB_S  in  1 each  load X / Y / S-input latch from SB.
- S_S  in  1  refresh the S-input latch from the S output.
- S_ADL  in  1  drive S onto ADL.
- SB_in  in  8  wired-AND value of all other SB drivers; 8'hFF when none.
- SB_out  out  8  resolved SB value.
- ADL_out  out  8  this block's ADL contribution; 8'hFF when not driving.
- PHI1, PHI2  out  1 each  one-hot half-cycle indicators.
- X_q, Y_q, S_q  out  8 each  register contents; S_q is the S output latch.
- SB_ERR  out  1  sticky SB multi-driver flag (see Configuration).

## Operation
- Phase bit ph toggles on every PHI0 rising edge. ph=0 is the PHI1 half and ph=1 is the PHI2 half. PHI1 = ~ph and PHI2 = ph.
- Drives are active only when PHI1=1 and n_RES=1:
  - SB_out = SB_in & (Y_SB ? Y : FF) & (X_SB ? X : FF) & (S_SB ? S_out : FF).
  - ADL_out = S_ADL ? S_out : FF.
- Drives in the PHI2 half or during reset:
  - SB_out = SB_in.
  - ADL_out = 8'hFF.
  - All control inputs are ignored.
- Edge ending a PHI1 half:
  - SB_X: X <= SB_out.
  - SB_Y: Y <= SB_out.
  - SB_S: S_in <= SB_out. Otherwise, if S_S: S_in <= S_out. Otherwise S_in holds.
  - SB_S has priority over S_S.
- Edge ending a PHI2 half: S_out <= S_in. X and Y are untouched.
- Simultaneous drive and load of the same register (e.g. X_SB with SB_X) loads the old value ANDed with the other drivers.
- S_SB/S_ADL together with SB_S in one PHI1 half: reads return the old S_out; the new value appears from the next PHI1 half.
- Multi-driver event: two or more of Y_SB/X_SB/S_SB are high in a PHI1 half. SB resolves by wired-AND, with no priority.

## Timing
- Reset (asynchronous, while n_RES=0):
  - ph=0, so PHI1=1 and PHI2=0.
  - X=Y=S_in=S_out=8'h00.
  - SB_out=SB_in, ADL_out=8'hFF, SB_ERR=0.
- Reset release: the first edge after release ends a PHI1 half.
- Reset asserted mid-operation clears all state immediately. A load pending at that edge is lost.
- SB_out and ADL_out are combinational from the inputs and state, with zero latency within the PHI1 half.
- Load-to-readback latency: a value written via SB_X, SB_Y or SB_S in PHI1 half n is driven on SB/ADL in PHI1 half n+1, which is 2 PHI0 edges later.
- S_q updates 1 edge after S_in; X_q and Y_q update on the PHI1-ending edge.
- Holding any control across a PHI2 half has no effect.
- A control that is high for only a PHI2 half is lost.

## Configuration
- REGS_SB_CHECK_EN defined:
  - SB_ERR is a register that is set at any PHI1-ending edge where a multi-driver event occurred.
  - It is cleared only by reset.
  - The bus data is not affected.
- REGS_SB_CHECK_EN undefined: SB_ERR is tied to 0 and no checking logic is synthesised.

## Test plan
- Reset: n_RES low mid-PHI2 with X=5A -> immediately PHI1=1, X_q=Y_q=S_q=00, ADL_out=FF, SB_out=SB_in.
- SB_in=3C with SB_X in PHI1 half 0, then X_SB in PHI1 half 1 with SB_in=FF -> X_q=3C after edge 1, SB_out=3C in half 1.
- S=10 and SB_in=7F with SB_S, S_ADL and S_SB all high in the same PHI1 half:
  - ADL_out=10 in that half.
  - SB_out=10&7F=10 in that half, so S_in loads 10.
  - Repeat with S_SB low: S_in=7F, S_q=7F after the PHI2 edge, and ADL_out=7F in the next PHI1 half.
- SB_S and S_S both high with SB_in=22 and S=99 -> S_q=22 (SB_S wins). With S_S alone -> S_q stays 99.
- Multi-driver: X=F0, Y=3C, X_SB and Y_SB in PHI1 -> SB_out=30. With REGS_SB_CHECK_EN, SB_ERR=1 from the next edge until reset; without it, SB_ERR stays 0.
- Controls asserted only in PHI2 halves (SB_Y, SB_in=AA) -> Y_q unchanged and SB_out=SB_in throughout.

Source files
------------

// File: rtl/regs_xys.sv
// X, Y and S index/stack registers on the special bus (SB) and low address bus (ADL).
// Optional SB multi-driver checking is enabled by defining REGS_SB_CHECK_EN.
module regs_xys (
  input  logic       PHI0,
  input  logic       n_RES,
  input  logic       Y_SB,
  input  logic       X_SB,
  input  logic       S_SB,
  input  logic       SB_X,
  input  logic       SB_Y,
  input  logic       SB_S,
  input  logic       S_S,
  input  logic       S_ADL,
  input  logic [7:0] SB_in,
  output logic [7:0] SB_out,
  output logic [7:0] ADL_out,
  output logic       PHI1,
  output logic       PHI2,
  output logic [7:0] X_q,
  output logic [7:0] Y_q,
  output logic [7:0] S_q,
  output logic       SB_ERR
);

  logic       ph_q;
  logic       ph_d;
  logic       drive_en;
  logic [7:0] s_in_q;
  logic [7:0] s_in_d;
  logic [7:0] x_d;
  logic [7:0] y_d;
  logic [7:0] s_out_d;

  assign PHI1     = ~ph_q;
  assign PHI2     = ph_q;
  assign drive_en = ~ph_q & n_RES;

  // Wired-AND bus: an idle driver contributes all ones.
  always_comb begin
    SB_out  = SB_in
            & ((drive_en && Y_SB) ? Y_q : 8'hFF)
            & ((drive_en && X_SB) ? X_q : 8'hFF)
            & ((drive_en && S_SB) ? S_q : 8'hFF);
    ADL_out = (drive_en && S_ADL) ? S_q : 8'hFF;
  end

  always_comb begin
    ph_d    = ~ph_q;
    x_d     = X_q;
    y_d     = Y_q;
    s_in_d  = s_in_q;
    s_out_d = S_q;
    if (!ph_q) begin
      if (SB_X) x_d = SB_out;
      if (SB_Y) y_d = SB_out;
      if (SB_S) begin
        s_in_d = SB_out;
      end else if (S_S) begin
        s_in_d = S_q;
      end
    end else begin
      // Output latch follows the input latch only across the PHI2 half.
      s_out_d = s_in_q;
    end
  end

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      ph_q   <= 1'b0;
      X_q    <= 8'h00;
      Y_q    <= 8'h00;
      s_in_q <= 8'h00;
      S_q    <= 8'h00;
    end else begin
      ph_q   <= ph_d;
      X_q    <= x_d;
      Y_q    <= y_d;
      s_in_q <= s_in_d;
      S_q    <= s_out_d;
    end
  end

`ifdef REGS_SB_CHECK_EN
  logic sb_err_q;
  logic multi_drv;

  assign multi_drv = drive_en & ((Y_SB & X_SB) | (Y_SB & S_SB) | (X_SB & S_SB));

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      sb_err_q <= 1'b0;
    end else if (multi_drv) begin
      sb_err_q <= 1'b1;
    end
  end

  assign SB_ERR = sb_err_q;
`else
  assign SB_ERR = 1'b0;
`endif

endmodule
